// File: rtl/dpll_pkg.sv
// Shared types and helpers for the DPLL bit-recovery slice.
//   vote_state_t  : mid-bit vote sequencer states
//   frame_state_t : sync-word hunt / locked states
//   DEFAULT_SYNC_WORD : frame marker, MSB received first
//   maj3()        : 3-input majority
package dpll_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    S1   = 2'd1,
    S2   = 2'd2
  } vote_state_t;

  typedef enum logic {
    HUNT = 1'b0,
    SYNC = 1'b1
  } frame_state_t;

  localparam logic [7:0] DEFAULT_SYNC_WORD = 8'hA5;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/dpll_bit_vote.sv
// Mid-bit sampler. Synchronizes the raw data line and the recovered clock,
// detects recovered-clock falling edges (mid-bit), then takes three samples
// GAP cycles apart and emits their majority as one recovered bit.
// Ports:
//   clk, rst     : 100 MHz clock, async active-high reset
//   clear        : synchronous abort of any vote in progress
//   signal       : raw serial data (asynchronous)
//   rec_clk      : recovered clock (asynchronous)
//   mid_edge     : one-cycle pulse, registered falling edge of synced rec_clk
//   bit_strobe   : one-cycle pulse, bit_val holds a fresh recovered bit
//   bit_val      : majority-voted bit
module dpll_bit_vote
  import dpll_pkg::*;
#(
  parameter int GAP = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic signal,
  input  logic rec_clk,
  output logic mid_edge,
  output logic bit_strobe,
  output logic bit_val
);

  localparam int GAP_W = $clog2(GAP + 1);

  logic        sig_s1_q, sig_s2_q;
  logic        rc_s1_q, rc_s2_q, rc_prev_q;
  logic        mid_edge_q, mid_edge_d;
  vote_state_t state_q, state_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic        a_q, a_d, b_q, b_d;
  logic        strobe_q, strobe_d;
  logic        bit_q, bit_d;

  assign mid_edge   = mid_edge_q;
  assign bit_strobe = strobe_q;
  assign bit_val    = bit_q;

  always_comb begin
    mid_edge_d = rc_prev_q & ~rc_s2_q;
    state_d    = state_q;
    gap_d      = gap_q;
    a_d        = a_q;
    b_d        = b_q;
    strobe_d   = 1'b0;
    bit_d      = bit_q;

    case (state_q)
      IDLE: begin
        // mid_edge only starts a vote from IDLE; edges mid-vote are dropped.
        if (mid_edge_q) begin
          a_d     = sig_s2_q;
          gap_d   = '0;
          state_d = S1;
        end
      end
      S1: begin
        if (gap_q == GAP_W'(GAP - 1)) begin
          b_d     = sig_s2_q;
          gap_d   = '0;
          state_d = S2;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      S2: begin
        if (gap_q == GAP_W'(GAP - 1)) begin
          // Third sample used directly; the result is presented next cycle.
          bit_d    = maj3(a_q, b_q, sig_s2_q);
          strobe_d = 1'b1;
          gap_d    = '0;
          state_d  = IDLE;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (clear) begin
      state_d  = IDLE;
      gap_d    = '0;
      a_d      = 1'b0;
      b_d      = 1'b0;
      strobe_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sig_s1_q   <= 1'b0;
      sig_s2_q   <= 1'b0;
      rc_s1_q    <= 1'b0;
      rc_s2_q    <= 1'b0;
      rc_prev_q  <= 1'b0;
      mid_edge_q <= 1'b0;
      state_q    <= IDLE;
      gap_q      <= '0;
      a_q        <= 1'b0;
      b_q        <= 1'b0;
      strobe_q   <= 1'b0;
      bit_q      <= 1'b0;
    end else begin
      sig_s1_q   <= signal;
      sig_s2_q   <= sig_s1_q;
      rc_s1_q    <= rec_clk;
      rc_s2_q    <= rc_s1_q;
      rc_prev_q  <= rc_s2_q;
      mid_edge_q <= mid_edge_d;
      state_q    <= state_d;
      gap_q      <= gap_d;
      a_q        <= a_d;
      b_q        <= b_d;
      strobe_q   <= strobe_d;
      bit_q      <= bit_d;
    end
  end

endmodule

// File: rtl/dpll_bit_recovery.sv
// Bit recovery behind the DPLL. Voted bits are shifted in MSB first; the
// frame FSM hunts for SYNC_WORD, then slices following bits into DATA_W-bit
// words held in a one-entry output buffer. A watchdog drops sync when the
// recovered clock stops.
// Handshake: a word transfers in any cycle where data_valid && data_ready;
// data_out is stable while data_valid && !data_ready; a completed word that
// cannot be buffered is dropped and overflow pulses for one cycle.
// Ports:
//   CLK_100MHz, reset : clock, async active-high reset
//   signal, rec_clk   : raw data and recovered clock (asynchronous)
//   data_out/valid/ready : word output, MSB = first received bit
//   in_sync           : sync word found and recovered clock present
//   overflow          : one-cycle pulse on a dropped word
module dpll_bit_recovery
  import dpll_pkg::*;
#(
  parameter int                DATA_W    = 8,
  parameter logic [DATA_W-1:0] SYNC_WORD = DATA_W'(DEFAULT_SYNC_WORD),
  parameter int                GAP       = 16,
  parameter int                TIMEOUT   = 400000
) (
  input  logic              CLK_100MHz,
  input  logic              reset,
  input  logic              signal,
  input  logic              rec_clk,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  input  logic              data_ready,
  output logic              in_sync,
  output logic              overflow
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int WD_W  = $clog2(TIMEOUT + 1);

  logic mid_edge, bit_strobe, bit_val, timeout;

  frame_state_t      frame_q, frame_d;
  logic [DATA_W-1:0] shift_q, shift_d, shifted;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [WD_W-1:0]   wd_cnt_q, wd_cnt_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              data_valid_q, data_valid_d;
  logic              in_sync_q, in_sync_d;
  logic              overflow_q, overflow_d;
  logic              word_done;

  dpll_bit_vote #(.GAP(GAP)) u_vote (
    .clk        (CLK_100MHz),
    .rst        (reset),
    .clear      (timeout),
    .signal     (signal),
    .rec_clk    (rec_clk),
    .mid_edge   (mid_edge),
    .bit_strobe (bit_strobe),
    .bit_val    (bit_val)
  );

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign in_sync    = in_sync_q;
  assign overflow   = overflow_q;

  // Timeout fires once, on the cycle the counter would reach TIMEOUT.
  assign timeout = !mid_edge && (wd_cnt_q == WD_W'(TIMEOUT - 1));
  assign shifted = {shift_q[DATA_W-2:0], bit_val};

  always_comb begin
    frame_d      = frame_q;
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    in_sync_d    = in_sync_q;
    data_out_d   = data_out_q;
    data_valid_d = data_valid_q;
    overflow_d   = 1'b0;
    word_done    = 1'b0;

    if (mid_edge) begin
      wd_cnt_d = '0;
    end else if (wd_cnt_q == WD_W'(TIMEOUT)) begin
      wd_cnt_d = wd_cnt_q;
    end else begin
      wd_cnt_d = wd_cnt_q + WD_W'(1);
    end

    if (bit_strobe) begin
      shift_d = shifted;
      case (frame_q)
        HUNT: begin
          if (shifted == SYNC_WORD) begin
            frame_d   = SYNC;
            bit_cnt_d = '0;
            in_sync_d = 1'b1;
          end
        end
        SYNC: begin
          if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
            bit_cnt_d = '0;
            word_done = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end
        default: frame_d = HUNT;
      endcase
    end

    if (data_valid_q && data_ready) begin
      data_valid_d = 1'b0;
    end

    if (timeout) begin
      // Loss of clock wins over a word completing in the same cycle.
      frame_d   = HUNT;
      shift_d   = '0;
      bit_cnt_d = '0;
      in_sync_d = 1'b0;
    end else if (word_done) begin
      if (!data_valid_q || data_ready) begin
        data_out_d   = shifted;
        data_valid_d = 1'b1;
      end else begin
        overflow_d = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK_100MHz or posedge reset) begin
    if (reset) begin
      frame_q      <= HUNT;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      wd_cnt_q     <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      in_sync_q    <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      frame_q      <= frame_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      wd_cnt_q     <= wd_cnt_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      in_sync_q    <= in_sync_d;
      overflow_q   <= overflow_d;
    end
  end

endmodule

// File: tb/tb_dpll_bit_recovery.sv
// Bench for dpll_bit_recovery with a shortened bit period (40 cycles),
// GAP = 4 and TIMEOUT = 200 so the whole run stays short.
module tb_dpll_bit_recovery;

  localparam int DATA_W  = 8;
  localparam int GAP     = 4;
  localparam int TIMEOUT = 200;
  localparam int HALF    = 20;

  logic              clk;
  logic              reset;
  logic              signal;
  logic              rec_clk;
  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic              data_ready;
  logic              in_sync;
  logic              overflow;

  logic [DATA_W-1:0] exp_q[$];
  int                total_cnt = 0;
  int                pass_cnt  = 0;
  int                ovf_cnt   = 0;
  int                valid_cyc = 0;

  dpll_bit_recovery #(
    .DATA_W    (DATA_W),
    .SYNC_WORD (8'hA5),
    .GAP       (GAP),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .CLK_100MHz (clk),
    .reset      (reset),
    .signal     (signal),
    .rec_clk    (rec_clk),
    .data_out   (data_out),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .in_sync    (in_sync),
    .overflow   (overflow)
  );

  // ---------------- clock / global time limit ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL time_limit: run did not complete, expected finish before 2000000");
    $fatal(1, "time limit");
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Monitor: every accepted word must match the head of the expected queue.
  always @(negedge clk) begin
    if (!reset) begin
      if (data_valid) valid_cyc++;
      if (overflow) ovf_cnt++;
      if (data_valid && data_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_word", {24'd0, data_out}, 32'hFFFF_FFFF);
        end else begin
          check("word", {24'd0, data_out}, {24'd0, exp_q.pop_front()});
        end
      end
    end
  end

  // ---------------- drivers ----------------
  // One bit: data changes with rec_clk rising, rec_clk falls mid-bit.
  // glitch inverts the line for 5 cycles starting at the falling edge.
  // rdy_at >= 1 raises data_ready that many cycles after the falling edge.
  task automatic send_bit(input logic b, input logic glitch, input int rdy_at);
    @(posedge clk); #1;
    signal  = b;
    rec_clk = 1'b1;
    repeat (HALF) @(posedge clk);
    #1;
    rec_clk = 1'b0;
    if (glitch) signal = ~b;
    for (int i = 1; i < HALF; i++) begin
      @(posedge clk); #1;
      if (glitch && i == 5) signal = b;
      if (i == rdy_at) data_ready = 1'b1;
    end
  endtask

  task automatic send_byte(input logic [7:0] v, input logic glitch, input int rdy_last);
    for (int i = 7; i >= 0; i--) send_bit(v[i], glitch, (i == 0) ? rdy_last : -1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] sw;
    reset      = 1'b1;
    signal     = 1'b0;
    rec_clk    = 1'b0;
    data_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("rst_data_out",   {24'd0, data_out}, 32'd0);
    check("rst_data_valid", {31'd0, data_valid}, 32'd0);
    check("rst_in_sync",    {31'd0, in_sync}, 32'd0);
    check("rst_overflow",   {31'd0, overflow}, 32'd0);
    reset = 1'b0;
    repeat (3) @(posedge clk);

    // Sync then data
    sw = 8'hA5;
    for (int i = 7; i >= 1; i--) send_bit(sw[i], 1'b0, -1);
    check("no_sync_before_8th", {31'd0, in_sync}, 32'd0);
    send_bit(sw[0], 1'b0, -1);
    check("sync_after_a5", {31'd0, in_sync}, 32'd1);
    valid_cyc = 0;
    exp_q.push_back(8'h3C);
    exp_q.push_back(8'hF0);
    send_byte(8'h3C, 1'b0, -1);
    send_byte(8'hF0, 1'b0, -1);
    check("one_valid_cycle_each", valid_cyc, 32'd2);

    // Glitch on the first vote sample of every bit
    exp_q.push_back(8'h96);
    send_byte(8'h96, 1'b1, -1);
    check("sync_kept_glitch", {31'd0, in_sync}, 32'd1);

    // Backpressure across two words
    data_ready = 1'b0;
    exp_q.push_back(8'h11);
    send_byte(8'h11, 1'b0, -1);
    check("bp_valid", {31'd0, data_valid}, 32'd1);
    check("bp_hold_11", {24'd0, data_out}, 32'h11);
    send_byte(8'h22, 1'b0, -1);
    check("bp_overflow_once", ovf_cnt, 32'd1);
    check("bp_still_11", {24'd0, data_out}, 32'h11);
    @(posedge clk); #1;
    data_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("bp_valid_drops", {31'd0, data_valid}, 32'd0);

    // Back-to-back: ready rises in the cycle the next word completes
    data_ready = 1'b0;
    exp_q.push_back(8'h33);
    exp_q.push_back(8'h44);
    send_byte(8'h33, 1'b0, -1);
    send_byte(8'h44, 1'b0, 12);
    check("b2b_no_overflow", ovf_cnt, 32'd1);
    check("b2b_queue_empty", exp_q.size(), 32'd0);

    // Clock loss mid-word
    send_bit(1'b1, 1'b0, -1);
    send_bit(1'b0, 1'b0, -1);
    send_bit(1'b1, 1'b0, -1);
    send_bit(1'b1, 1'b0, -1);
    repeat (TIMEOUT - 20) @(posedge clk);
    #1;
    check("loss_sync_held", {31'd0, in_sync}, 32'd1);
    repeat (10) @(posedge clk);
    #1;
    check("loss_sync_dropped", {31'd0, in_sync}, 32'd0);
    check("loss_no_partial", {31'd0, data_valid}, 32'd0);
    send_byte(8'h77, 1'b0, -1);
    check("no_resync_without_a5", {31'd0, in_sync}, 32'd0);
    send_byte(8'hA5, 1'b0, -1);
    check("resync_a5", {31'd0, in_sync}, 32'd1);
    exp_q.push_back(8'h5C);
    send_byte(8'h5C, 1'b0, -1);

    // Async reset with a word pending and a vote in flight
    data_ready = 1'b0;
    send_byte(8'h99, 1'b0, -1);
    check("pre_reset_valid", {31'd0, data_valid}, 32'd1);
    @(posedge clk); #1;
    signal  = 1'b1;
    rec_clk = 1'b1;
    repeat (HALF) @(posedge clk);
    #1;
    rec_clk = 1'b0;
    repeat (6) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("arst_data_out",   {24'd0, data_out}, 32'd0);
    check("arst_data_valid", {31'd0, data_valid}, 32'd0);
    check("arst_in_sync",    {31'd0, in_sync}, 32'd0);
    check("arst_overflow",   {31'd0, overflow}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset      = 1'b0;
    data_ready = 1'b1;
    send_byte(8'hA5, 1'b0, -1);
    check("post_reset_sync", {31'd0, in_sync}, 32'd1);
    exp_q.push_back(8'hC3);
    send_byte(8'hC3, 1'b0, -1);

    repeat (5) @(posedge clk);
    #1;
    check("final_queue_empty", exp_q.size(), 32'd0);
    check("final_overflow_total", ovf_cnt, 32'd1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
